delay_checker: RTL and testbench
================================

# delay_checker

Receive-side monitor for the periodic `sig` tick produced by the team's DELAY pulse generator, which asserts `sig` for one cycle every N+1 clocks. The checker samples `sig`, measures the interval between consecutive ticks, and declares lock after LOCK_CNT consecutive in-tolerance intervals. It flags early ticks, late ticks and missing ticks with a one-cycle `err` pulse, a sticky `fault` and a saturating violation count. It sits beside the generator in the same clock domain and feeds status to the system controller.

## Interface
- N, 100000: generator terminal count; the nominal tick interval is N+1 clocks.
- TOL, 0: accepted deviation from N+1, in clocks, either side. Constraint: TOL < N.
- LOCK_CNT, 2: number of consecutive good intervals required to lock (range 1..15).
- CBITS, 17: elapsed-counter width. Must hold N+TOL.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low; all state clears while low.
- sig  in  1  tick input from the generator, synchronous to clk.
- clr  in  1  synchronous clear of `fault`, `miss_cnt` and the state machine.
- locked  out  1  interval tracking is locked.
- err  out  1  one-cycle pulse per violation.
- fault  out  1  sticky; set by any violation, cleared only by clr or rst.
- flg  out  1  acceptance window open (a tick now would be good).
- miss_cnt  out  8  saturating violation count; holds at 255.

## Operation
- Elapsed counter `e` (CBITS bits):
  - Loads 0 on every edge where `sig`=1.
  - Increments on edges where `sig`=0, in TRACK or LOCKED only.
  - Held at 0 in IDLE.
  - Never exceeds N+TOL, because a timeout fires first.
- Interval classification on a tick, using the value of `e` before the edge:
  - good: N-TOL ≤ e ≤ N+TOL, i.e. interval N+1±TOL.
  - early: e < N-TOL.
  - timeout: `sig`=0 while e == N+TOL, in TRACK or LOCKED.
- Good-interval counter `g` (4 bits): counts consecutive good intervals and saturates at LOCK_CNT.
- States:
  - IDLE:
    - Reset and clr target.
    - A tick moves to TRACK with e=0, g=0.
    - No timeout is raised in IDLE.
  - TRACK:
    - A good tick increments g. If g+1 == LOCK_CNT, move to LOCKED.
    - An early tick is a violation: g=0, stay in TRACK, e=0. The early tick becomes the new reference.
    - A timeout is a violation: move to IDLE, e=0.
  - LOCKED:
    - A good tick stays in LOCKED.
    - An early tick is a violation: move to TRACK, g=0, e=0.
    - A timeout is a violation: move to IDLE.
- Every violation, on the same edge:
  - err=1 for exactly one cycle.
  - fault=1.
  - miss_cnt incremented, saturating at 255.
- Output decoding:
  - locked = (state == LOCKED).
  - flg = (state != IDLE) and (N-TOL ≤ e ≤ N+TOL). flg is decoded from registered state with no added latency.
- Simultaneous events:
  - clr together with a tick or timeout: clr wins. The next state is IDLE, there is no err, fault=0, miss_cnt=0, and the tick is ignored.
  - A tick on the edge where e == N+TOL is good, not a timeout.

## Timing
- Reset values: locked=0, err=0, fault=0, flg=0, miss_cnt=0, state IDLE, e=0, g=0.
- All outputs are registered or decoded from registers. A `sig` sampled at edge k affects the outputs from edge k onward, visible in cycle k+1.
- Timeout fires at edge k+N+TOL+1 after a tick sampled at edge k, if no tick arrives in between.
- Lock latency from the first tick is LOCK_CNT good intervals. `locked` rises on the edge that samples tick number LOCK_CNT+1.
- rst deassertion is synchronous to clk; no edge is sampled while rst is low.
- rst asserted mid-operation clears everything immediately, regardless of clk.

## Test plan
Bench parameters: N=10, TOL=1, LOCK_CNT=2. The nominal interval is 11 clocks and the good window is 10..12.

- Reset: hold rst=0 with sig toggling → all outputs are 0. Release rst with no ticks for 50 cycles → stays IDLE, err never asserts.
- Lock: ticks every 11 cycles → TRACK after tick 1, locked=1 after tick 3, err=0 throughout. flg is high for cycles where e=9..11.
- Tolerance edges: intervals of 10 and 12 → good, locked is maintained. An interval of 9 → early, so err pulses once, fault=1, locked=0, miss_cnt=1.
- Missing tick: while locked, stop ticks → err at edge 12 after the last tick, state IDLE, miss_cnt increments. Resume ticks → relocks after 3 ticks; fault stays 1.
- clr collision: assert clr on the same edge as an early tick → no err, fault=0, miss_cnt=0, state IDLE. The next tick starts TRACK.
- Saturation and async reset: 300 early ticks → miss_cnt=255 and held there. Pulse rst low mid-interval → all outputs are 0 immediately.

Source files
------------

// File: rtl/delay_checker_if.sv
// delay_checker_if: bundles the tick input, clear and status outputs of the
// delay checker so the system controller side and the checker share one port.
interface delay_checker_if;
   logic       sig;
   logic       clr;
   logic       locked;
   logic       err;
   logic       fault;
   logic       flg;
   logic [7:0] miss_cnt;

   // Controller / generator side: drives tick and clear, observes status.
   modport master (
      output sig,
      output clr,
      input  locked,
      input  err,
      input  fault,
      input  flg,
      input  miss_cnt
   );

   // Checker side: observes tick and clear, drives status.
   modport slave (
      input  sig,
      input  clr,
      output locked,
      output err,
      output fault,
      output flg,
      output miss_cnt
   );
endinterface

// File: rtl/delay_checker.sv
// delay_checker: measures the spacing of periodic one-cycle ticks, locks after
// LOCK_CNT consecutive in-tolerance intervals, and reports early, late and
// missing ticks through a one-cycle err pulse, a sticky fault and a
// saturating violation count.
module delay_checker #(
   parameter int N        = 100000,
   parameter int TOL      = 0,
   parameter int LOCK_CNT = 2,
   parameter int CBITS    = 17
) (
   input logic            clk,
   input logic            rst,
   delay_checker_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Acceptance window on the elapsed count taken before the tick edge.
   localparam logic [CBITS-1:0] E_LO   = CBITS'(N - TOL);
   localparam logic [CBITS-1:0] E_HI   = CBITS'(N + TOL);
   localparam logic [3:0]       LOCK_G = 4'(LOCK_CNT);

   // Increment that sticks at the top of the 8-bit range.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'd255) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CBITS-1:0] e_r;
   logic [CBITS-1:0] e_nxt_s;
   logic [3:0]       g_r;
   logic [3:0]       g_nxt_s;
   logic             viol_s;

   logic             err_r;
   logic             fault_r;
   logic [7:0]       miss_r;
   logic             err_nxt_s;
   logic             fault_nxt_s;
   logic [7:0]       miss_nxt_s;
   logic             locked_s;
   logic             flg_s;

   logic             in_win_s;
   logic             at_limit_s;

   assign in_win_s   = (e_r >= E_LO) && (e_r <= E_HI);
   assign at_limit_s = (e_r == E_HI);

   // State, elapsed counter and good-interval counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         e_r     <= '0;
         g_r     <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         e_r     <= e_nxt_s;
         g_r     <= g_nxt_s;
      end
   end

   // Next-state logic: classify each tick or timeout against the window.
   always_comb begin
      state_nxt_s = state_r;
      e_nxt_s     = e_r;
      g_nxt_s     = g_r;
      viol_s      = 1'b0;
      if (bus.clr) begin
         // Clear dominates any tick or timeout on the same edge.
         state_nxt_s = ST_IDLE;
         e_nxt_s     = '0;
         g_nxt_s     = 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               e_nxt_s = '0;
               g_nxt_s = 4'd0;
               if (bus.sig) begin
                  state_nxt_s = ST_TRACK;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_TRACK, ST_LOCKED: begin
               if (bus.sig) begin
                  // Every tick becomes the new reference point.
                  e_nxt_s = '0;
                  if (in_win_s) begin
                     if ((g_r + 4'd1) >= LOCK_G) begin
                        state_nxt_s = ST_LOCKED;
                        g_nxt_s     = LOCK_G;
                     end else begin
                        state_nxt_s = state_r;
                        g_nxt_s     = g_r + 4'd1;
                     end
                  end else begin
                     // Window not reached yet: the tick is early.
                     viol_s      = 1'b1;
                     state_nxt_s = ST_TRACK;
                     g_nxt_s     = 4'd0;
                  end
               end else if (at_limit_s) begin
                  // Last acceptable edge passed without a tick.
                  viol_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
                  e_nxt_s     = '0;
                  g_nxt_s     = 4'd0;
               end else begin
                  e_nxt_s = e_r + {{(CBITS-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               e_nxt_s     = '0;
               g_nxt_s     = 4'd0;
            end
         endcase
      end
   end

   // Output logic: next values of the event outputs and status decodes.
   always_comb begin
      err_nxt_s = viol_s;
      if (bus.clr) begin
         fault_nxt_s = 1'b0;
         miss_nxt_s  = 8'd0;
      end else if (viol_s) begin
         fault_nxt_s = 1'b1;
         miss_nxt_s  = sat_inc(miss_r);
      end else begin
         fault_nxt_s = fault_r;
         miss_nxt_s  = miss_r;
      end
      locked_s = (state_r == ST_LOCKED);
      flg_s    = (state_r != ST_IDLE) && in_win_s;
   end

   // Registered event outputs: err pulse, sticky fault, violation count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r   <= 1'b0;
         fault_r <= 1'b0;
         miss_r  <= 8'd0;
      end else begin
         err_r   <= err_nxt_s;
         fault_r <= fault_nxt_s;
         miss_r  <= miss_nxt_s;
      end
   end

   assign bus.locked   = locked_s;
   assign bus.err      = err_r;
   assign bus.fault    = fault_r;
   assign bus.flg      = flg_s;
   assign bus.miss_cnt = miss_r;

endmodule

// File: tb/tb_delay_checker.sv
// tb_delay_checker: directed and randomized tick streams; a timestamp-based
// reference model predicts outputs per edge into a queue that a separate
// monitor drains and compares against the checker.
module tb_delay_checker;

   localparam int N   = 10;
   localparam int TOL = 1;
   localparam int LC  = 2;

   localparam int M_IDLE   = 0;
   localparam int M_TRACK  = 1;
   localparam int M_LOCKED = 2;

   typedef struct {
      int         edge_n;
      logic [11:0] val;
   } exp_t;

   logic clk;
   logic rst;

   delay_checker_if dc_if ();

   delay_checker #(.N(N), .TOL(TOL), .LOCK_CNT(LC), .CBITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dc_if)
   );

   exp_t q[$];
   int   vectors;
   int   miscompares;

   // Reference model state: edge counter and timestamp of the last tick.
   int m_now;
   int m_ref;
   int m_mode;
   int m_run;
   bit m_err;
   bit m_fault;
   int m_miss;
   bit m_flg;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string nm, input int edge_n,
                      input logic [11:0] got, input logic [11:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s edge %0d: got lk=%0b err=%0b flt=%0b flg=%0b miss=%0d, want lk=%0b err=%0b flt=%0b flg=%0b miss=%0d",
                  nm, edge_n, got[11], got[10], got[9], got[8], got[7:0],
                  want[11], want[10], want[9], want[8], want[7:0]);
      end
   endtask

   function automatic logic [11:0] dut_out();
      return {dc_if.locked, dc_if.err, dc_if.fault, dc_if.flg, dc_if.miss_cnt};
   endfunction

   function automatic logic [11:0] model_out();
      logic [7:0] mm;
      mm = 8'(m_miss);
      return {(m_mode == M_LOCKED), m_err, m_fault, m_flg, mm};
   endfunction

   task automatic violation();
      m_err   = 1'b1;
      m_fault = 1'b1;
      if (m_miss < 255) m_miss = m_miss + 1;
   endtask

   // Predict outputs after one clock edge from interval lengths in edges.
   task automatic model(input bit s, input bit c, input bit r);
      int iv;
      if (!r) begin
         m_now = 0; m_ref = 0; m_mode = M_IDLE; m_run = 0;
         m_err = 1'b0; m_fault = 1'b0; m_miss = 0;
      end else begin
         m_now = m_now + 1;
         m_err = 1'b0;
         if (c) begin
            m_mode = M_IDLE; m_run = 0; m_fault = 1'b0; m_miss = 0;
         end else if (m_mode == M_IDLE) begin
            if (s) begin
               m_mode = M_TRACK; m_ref = m_now; m_run = 0;
            end
         end else begin
            iv = m_now - m_ref;
            if (s) begin
               m_ref = m_now;
               if (iv >= N + 1 - TOL && iv <= N + 1 + TOL) begin
                  m_run = m_run + 1;
                  if (m_run >= LC) m_mode = M_LOCKED;
               end else begin
                  violation();
                  m_mode = M_TRACK;
                  m_run  = 0;
               end
            end else if (iv == N + TOL + 1) begin
               violation();
               m_mode = M_IDLE;
               m_run  = 0;
            end
         end
      end
      m_flg = (m_mode != M_IDLE) && (m_now - m_ref >= N - TOL) && (m_now - m_ref <= N + TOL);
   endtask

   // Drive one cycle of stimulus and queue the predicted response.
   task automatic step(input bit s, input bit c, input bit r);
      exp_t x;
      @(negedge clk);
      dc_if.sig = s;
      dc_if.clr = c;
      rst       = r;
      model(s, c, r);
      x.edge_n = m_now;
      x.val    = model_out();
      q.push_back(x);
   endtask

   // One interval of iv edges: iv-1 quiet cycles then a tick.
   task automatic interval(input int iv, input bit clr_on_tick);
      for (int i = 0; i < iv - 1; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, clr_on_tick, 1'b1);
   endtask

   // Monitor: compare the oldest prediction each cycle, away from the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            cmp("outputs", x.edge_n, dut_out(), x.val);
         end
      end
   end

   initial begin
      int iv;
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      dc_if.sig   = 1'b0;
      dc_if.clr   = 1'b0;
      model(1'b0, 1'b0, 1'b0);

      // Reset held with sig toggling, then idle with no ticks.
      for (int i = 0; i < 6; i++) step(i[0], 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);

      // Nominal lock, then tolerance edges and an early tick.
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) interval(11, 1'b0);
      interval(10, 1'b0);
      interval(12, 1'b0);
      interval(10, 1'b0);
      interval(12, 1'b0);
      interval(9, 1'b0);

      // Relock, missing tick, resume.
      for (int i = 0; i < 3; i++) interval(11, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) interval(11, 1'b0);

      // clr on the same edge as an early tick, then restart tracking.
      interval(11, 1'b0);
      interval(7, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) interval(11, 1'b0);

      // Randomized intervals around the window with sporadic clears.
      for (int k = 0; k < 60; k++) begin
         iv = int'($urandom_range(1, 14));
         for (int i = 0; i < iv - 1; i++) step(1'b0, ($urandom_range(0, 39) == 0), 1'b1);
         step(1'b1, ($urandom_range(0, 29) == 0), 1'b1);
      end

      // Saturation: a run of early ticks well past 255 violations.
      step(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 300; k++) interval(int'($urandom_range(1, 9)), 1'b0);
      interval(5, 1'b0);
      interval(11, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

      // Asynchronous reset pulse between edges, checked immediately.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      cmp("async_rst", m_now, dut_out(), 12'd0);
      model(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) interval(11, 1'b0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending predictions, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
